debounce_edge: RTL and testbench

Debounce-and-edge stage consuming the single-bit level produced by a D flip-flop stage, e.g. a registered button or status line. It resynchronizes the level into the local `clk` domain and accepts a new level only after it has held for `STABLE_CYCLES` consecutive cycles. It then emits the clean level, one-cycle rise/fall pulses and a running count of accepted transitions for downstream control logic.

---
 rtl/debounce_edge.sv | 107 ++++++++++
 tb/tb_debounce_edge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// Resynchronizes an asynchronous level, accepts it after STABLE_CYCLES steady
// cycles, and emits the clean level, rise/fall pulses and a transition count.
module debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic             clr_cnt,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {STABLE, PENDING} state_t;

    logic          s1, s2;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          accept;

    // Two-flop synchronizer; only s2 is trusted downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    // cnt holds the number of mismatched cycles already seen, so the first
    // mismatch observed in STABLE counts as one; with a single required cycle
    // that first mismatch is itself the acceptance.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        case (state)
            STABLE: begin
                cnt_nx = '0;
                if (s2 != q) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_nx = PENDING;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            PENDING: begin
                if (s2 == q) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    accept   = 1'b1;
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = STABLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Registered outputs: level, single-cycle pulses, transition counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            rise <= accept & s2;
            fall <= accept & ~s2;
            if (accept) begin
                q <= s2;
            end
            if (clr_cnt) begin
                edge_cnt <= '0;
            end else if (accept) begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Checks debounce_edge (default and 2-bit counter instances) against a model
// that accepts a level once the last STABLE_CYCLES synchronized samples differ from q.
module tb_debounce_edge;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n, d, clr_cnt;
    logic       q, rise, fall;
    logic [7:0] edge_cnt;
    logic       q2, rise2, fall2;
    logic [1:0] edge_cnt2;

    int errors = 0;
    int checks = 0;

    // dh[0] is the most recent sampled d; s2 before an edge equals dh[1]
    logic dh [0:SC+1];
    logic q_m, rise_m, fall_m;
    int   edge_m;

    debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .clr_cnt(clr_cnt),
        .q(q), .rise(rise), .fall(fall), .edge_cnt(edge_cnt)
    );

    debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .d(d), .clr_cnt(clr_cnt),
        .q(q2), .rise(rise2), .fall(fall2), .edge_cnt(edge_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic will_accept();
        for (int i = 1; i <= SC; i++) begin
            if (dh[i] == q_m) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= SC + 1; i++) dh[i] = 1'b0;
        q_m = 1'b0; rise_m = 1'b0; fall_m = 1'b0; edge_m = 0;
    endtask

    task automatic check_all();
        check("q", q, q_m);
        check("rise", rise, rise_m);
        check("fall", fall, fall_m);
        check("edge_cnt", edge_cnt, edge_m % 256);
        check("q2", q2, q_m);
        check("rise2", rise2, rise_m);
        check("fall2", fall2, fall_m);
        check("edge_cnt2", edge_cnt2, edge_m % 4);
        check("excl", rise & fall, 0);
    endtask

    task automatic tick();
        logic acc;
        acc    = will_accept();
        rise_m = acc & ~q_m;
        fall_m = acc & q_m;
        if (acc) q_m = ~q_m;
        if (clr_cnt) edge_m = 0;
        else if (acc) edge_m++;
        for (int i = SC + 1; i >= 1; i--) dh[i] = dh[i-1];
        dh[0] = d;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic hold(input logic val, input int n);
        d = val;
        repeat (n) tick();
    endtask

    initial begin
        int wrap_exp [5] = '{1, 2, 3, 0, 1};
        int rise_at;
        logic fired;

        // reset and idle
        rst_n = 1'b0; d = 1'b0; clr_cnt = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        hold(1'b0, 20);

        // accept rise then fall
        hold(1'b1, 10);
        check("rise_done", q, 1);
        hold(1'b0, 10);
        check("fall_cnt", edge_cnt, 2);

        // glitch boundary: 3 cycles rejected, 4 accepted
        hold(1'b1, 3);
        hold(1'b0, 10);
        check("glitch3_q", q, 0);
        hold(1'b1, 4);
        hold(1'b0, 1);
        hold(1'b0, 9);
        check("accept4_cnt", edge_cnt, 4);

        // chatter
        for (int i = 0; i < 20; i++) hold(i[0] ? 1'b0 : 1'b1, 2);
        hold(1'b0, 10);
        check("chatter_cnt", edge_cnt, 4);

        // randomized holds
        repeat (40) hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));

        // wrap of the 2-bit counter and clear coinciding with acceptance
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int j = 0; j < 5; j++) begin
            d = ~q_m;
            fired = 1'b0;
            for (int k = 0; k < 12 && !fired; k++) begin
                tick();
                fired = rise_m | fall_m;
            end
            check("wrap_fired", fired, 1);
            check("wrap_val", edge_cnt2, wrap_exp[j]);
        end
        d = ~q_m;
        fired = 1'b0;
        for (int k = 0; k < 12 && !fired; k++) begin
            clr_cnt = will_accept();
            tick();
            fired = rise_m | fall_m;
        end
        clr_cnt = 1'b0;
        check("clr_pulse", rise2 | fall2, 1);
        check("clr_cnt2", edge_cnt2, 0);
        check("clr_cnt8", edge_cnt, 0);

        // reset while PENDING with cnt at 2
        hold(1'b0, 10);
        hold(1'b1, 1);
        hold(1'b1, 1);
        hold(1'b1, 1);
        hold(1'b0, 0);
        d = 1'b1;
        tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        rise_at = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rise && rise_at < 0) rise_at = k;
        end
        check("rst_latency", rise_at, 5);
        check("rst_edge_cnt", edge_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
